// File: rtl/buyruk_tamponu_pkg.sv
// Shared definitions for the instruction realignment buffer.
// Contents:
//   BUYRUK_TAM       - low two bits of a halfword that starts a 32-bit instruction
//   YARIM            - halfword width in bits
//   durum_t          - buffer state (NORMAL / HEDEF_BEKLE)
//   sikistirilmis_mi - true when a halfword starts a 16-bit compressed instruction
package buyruk_paket;

  localparam logic [1:0] BUYRUK_TAM = 2'b11;
  localparam int         YARIM      = 16;

  // HEDEF_BEKLE: a redirect landed mid-block; the next accepted block has
  // its leading halfwords dropped.
  typedef enum logic {
    NORMAL      = 1'b0,
    HEDEF_BEKLE = 1'b1
  } durum_t;

  function automatic logic sikistirilmis_mi(input logic [15:0] yarim_kelime);
    return yarim_kelime[1:0] != BUYRUK_TAM;
  endfunction

endpackage

// File: rtl/buyruk_tamponu_if.sv
// Bus bundle for buyruk_tamponu.
// Fetch side : getir_gecerli_i, getir_buyruk_i, getir_ps_i, getir_hazir_o
// Redirect   : ps_atladi_i, hedef_ps_i
// Decode side: buyruk_o, ps_o, sikistirilmis_o, buyruk_gecerli_o, buyruk_hazir_i
// Debug      : durum_o (FSM state), sayac_o (halfwords held)
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. Valid never depends on ready of the same channel; ready may be
// low while valid is high and the offered data is then simply held/re-offered.
// getir_hazir_o depends only on registered occupancy.
// slave modport = the buffer, master modport = its environment.
interface buyruk_tamponu_if #(
  parameter int GETIRME_GENISLIK = 32,
  parameter int DERINLIK_YARIM   = 8
);
  localparam int SW = $clog2(DERINLIK_YARIM) + 1;

  logic                        getir_gecerli_i;
  logic [GETIRME_GENISLIK-1:0] getir_buyruk_i;
  logic [31:0]                 getir_ps_i;
  logic                        getir_hazir_o;
  logic                        ps_atladi_i;
  logic [31:0]                 hedef_ps_i;
  logic [31:0]                 buyruk_o;
  logic [31:0]                 ps_o;
  logic                        sikistirilmis_o;
  logic                        buyruk_gecerli_o;
  logic                        buyruk_hazir_i;
  logic                        durum_o;
  logic [SW-1:0]               sayac_o;

  modport slave (
    input  getir_gecerli_i, getir_buyruk_i, getir_ps_i, ps_atladi_i,
           hedef_ps_i, buyruk_hazir_i,
    output getir_hazir_o, buyruk_o, ps_o, sikistirilmis_o, buyruk_gecerli_o,
           durum_o, sayac_o
  );

  modport master (
    output getir_gecerli_i, getir_buyruk_i, getir_ps_i, ps_atladi_i,
           hedef_ps_i, buyruk_hazir_i,
    input  getir_hazir_o, buyruk_o, ps_o, sikistirilmis_o, buyruk_gecerli_o,
           durum_o, sayac_o
  );
endinterface

// File: rtl/buyruk_tamponu_yarim_kelime_fifo.sv
// Circular halfword store.
// Ports:
//   clk_i, rst_i (sync, active-low)
//   temizle_i   - empty the store
//   yaz_i       - write halfwords atla_i..H-1 of veri_i at the write pointer
//   veri_i      - H halfwords, halfword 0 in [15:0]
//   atla_i      - number of leading halfwords to skip on this write
//   oku_adet_i  - halfwords consumed this cycle (0, 1 or 2)
//   bas0_o/bas1_o - halfwords at head and head+1
//   sayac_o     - halfwords currently held
module yarim_kelime_fifo #(
  parameter int H              = 2,
  parameter int DERINLIK_YARIM = 8,
  parameter int AW             = $clog2(H),
  parameter int SW             = $clog2(DERINLIK_YARIM) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            temizle_i,
  input  logic            yaz_i,
  input  logic [H*16-1:0] veri_i,
  input  logic [AW-1:0]   atla_i,
  input  logic [1:0]      oku_adet_i,
  output logic [15:0]     bas0_o,
  output logic [15:0]     bas1_o,
  output logic [SW-1:0]   sayac_o
);
  localparam int PW = $clog2(DERINLIK_YARIM);

  logic [15:0]   mem [DERINLIK_YARIM];
  logic [PW-1:0] oku_q, yaz_q;
  logic [SW-1:0] sayac_q;
  logic [SW-1:0] yazilan;

  assign yazilan = yaz_i ? (SW'(H) - SW'(atla_i)) : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_i || temizle_i) begin
      oku_q   <= '0;
      yaz_q   <= '0;
      sayac_q <= '0;
    end else begin
      oku_q   <= oku_q + PW'(oku_adet_i);
      yaz_q   <= yaz_q + PW'(yazilan);
      sayac_q <= sayac_q + yazilan - SW'(oku_adet_i);
    end
  end

  // Skipped halfwords are compacted out: halfword i lands at yaz+(i-atla).
  // Pointer arithmetic wraps for free because the depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (yaz_i) begin
      for (int i = 0; i < H; i++) begin
        if (i >= int'(atla_i))
          mem[yaz_q + PW'(i) - PW'(atla_i)] <= veri_i[i*16 +: 16];
      end
    end
  end

  assign bas0_o  = mem[oku_q];
  assign bas1_o  = mem[oku_q + PW'(1)];
  assign sayac_o = sayac_q;

endmodule

// File: rtl/buyruk_tamponu.sv
// Instruction realignment buffer between fetch and decode (RV32IC).
// Ports:
//   clk_i, rst_i (sync, active-low)
//   bus - buyruk_tamponu_if.slave: fetch blocks in, one 16/32-bit
//         instruction out per cycle with its PC, plus redirect strobe.
// Extraction is combinational from the head of the halfword store.
module buyruk_tamponu
  import buyruk_paket::*;
#(
  parameter int GETIRME_GENISLIK = 32,
  parameter int DERINLIK_YARIM   = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  buyruk_tamponu_if.slave     bus
);
  localparam int H  = GETIRME_GENISLIK / YARIM;
  localparam int AW = $clog2(H);
  localparam int SW = $clog2(DERINLIK_YARIM) + 1;

  logic [15:0]   bas0, bas1;
  logic [SW-1:0] sayac;
  durum_t        durum_q, durum_d;
  logic [AW-1:0] atla_q, atla_d, atla_w;
  logic [31:0]   bas_ps_q, bas_ps_d;
  logic          sik, gecerli, push, pop, hazir;
  logic [1:0]    oku_adet;

  yarim_kelime_fifo #(
    .H(H), .DERINLIK_YARIM(DERINLIK_YARIM), .AW(AW), .SW(SW)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .temizle_i  (bus.ps_atladi_i),
    .yaz_i      (push),
    .veri_i     (bus.getir_buyruk_i),
    .atla_i     (atla_w),
    .oku_adet_i (oku_adet),
    .bas0_o     (bas0),
    .bas1_o     (bas1),
    .sayac_o    (sayac)
  );

  // Room for a whole block, judged on registered occupancy only.
  assign hazir = (sayac + SW'(H)) <= SW'(DERINLIK_YARIM);

  assign sik = sikistirilmis_mi(bas0);
  // A full instruction with only its lower half present is held back.
  assign gecerli = !bus.ps_atladi_i &&
                   (sik ? (sayac != '0) : (sayac >= SW'(2)));
  assign push     = bus.getir_gecerli_i && hazir && !bus.ps_atladi_i;
  assign pop      = gecerli && bus.buyruk_hazir_i;
  assign oku_adet = pop ? (sik ? 2'd1 : 2'd2) : 2'd0;
  assign atla_w   = (durum_q == HEDEF_BEKLE) ? atla_q : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      durum_q  <= NORMAL;
      atla_q   <= '0;
      bas_ps_q <= '0;
    end else begin
      durum_q  <= durum_d;
      atla_q   <= atla_d;
      bas_ps_q <= bas_ps_d;
    end
  end

  always_comb begin
    durum_d  = durum_q;
    atla_d   = atla_q;
    bas_ps_d = bas_ps_q;
    if (bus.ps_atladi_i) begin
      bas_ps_d = bus.hedef_ps_i;
      atla_d   = bus.hedef_ps_i[AW:1];
      durum_d  = (bus.hedef_ps_i[AW:1] != '0) ? HEDEF_BEKLE : NORMAL;
    end else begin
      if (pop)
        bas_ps_d = bas_ps_q + (sik ? 32'd2 : 32'd4);
      if (push) begin
        // After a redirect the PC is already the target; do not reload it.
        if (durum_q == HEDEF_BEKLE)
          durum_d = NORMAL;
        else if (sayac == '0)
          bas_ps_d = bus.getir_ps_i;
      end
    end
  end

  assign bus.getir_hazir_o    = hazir;
  assign bus.buyruk_gecerli_o = gecerli;
  assign bus.sikistirilmis_o  = gecerli && sik;
  assign bus.buyruk_o         = !gecerli ? 32'd0 :
                                sik ? {16'd0, bas0} : {bas1, bas0};
  assign bus.ps_o             = bas_ps_q;
  assign bus.durum_o          = durum_q;
  assign bus.sayac_o          = sayac;

endmodule

// File: tb/tb_buyruk_tamponu.sv
module tb_buyruk_tamponu;
  localparam int GG = 32;
  localparam int D  = 8;
  localparam int H  = GG / 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  buyruk_tamponu_if #(.GETIRME_GENISLIK(GG), .DERINLIK_YARIM(D)) bus ();

  buyruk_tamponu #(.GETIRME_GENISLIK(GG), .DERINLIK_YARIM(D)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];     // halfwords the buffer must hold, head first
  logic [31:0] m_ps;         // PC of the head halfword
  bit          m_bekle;      // waiting for the first block after a mid-block redirect
  int          m_atla;       // halfwords to drop from that block
  bit          model_known = 0;

  logic [31:0] c_buyruk, c_ps;
  logic        c_sik, c_gec, c_hazir, c_durum;
  int          c_sayac;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance the model.
  task automatic step(input bit r, input bit g, input logic [GG-1:0] d,
                      input logic [31:0] p, input bit atl, input logic [31:0] hd,
                      input bit hz);
    bit          e_val, e_sik, e_hazir, was_empty;
    logic [31:0] e_b;
    int          from;
    rst                 = r;
    bus.getir_gecerli_i = g;
    bus.getir_buyruk_i  = d;
    bus.getir_ps_i      = p;
    bus.ps_atladi_i     = atl;
    bus.hedef_ps_i      = hd;
    bus.buyruk_hazir_i  = hz;
    #1;
    c_buyruk = bus.buyruk_o;
    c_ps     = bus.ps_o;
    c_sik    = bus.sikistirilmis_o;
    c_gec    = bus.buyruk_gecerli_o;
    c_hazir  = bus.getir_hazir_o;
    c_durum  = bus.durum_o;
    c_sayac  = int'(bus.sayac_o);

    e_hazir = (exp_q.size() + H <= D);
    e_val = 0; e_sik = 0; e_b = 32'd0;
    if (!atl && exp_q.size() >= 1) begin
      if (exp_q[0][1:0] != 2'b11) begin
        e_val = 1; e_sik = 1; e_b = {16'd0, exp_q[0]};
      end else if (exp_q.size() >= 2) begin
        e_val = 1; e_b = {exp_q[1], exp_q[0]};
      end
    end

    if (model_known) begin
      chk("gecerli", {31'd0, c_gec}, {31'd0, e_val});
      chk("buyruk", c_buyruk, e_b);
      chk("ps", c_ps, m_ps);
      chk("sik", {31'd0, c_sik}, {31'd0, e_sik});
      chk("getir_hazir", {31'd0, c_hazir}, {31'd0, e_hazir});
      chk("sayac", c_sayac, exp_q.size());
      chk("durum", {31'd0, c_durum}, {31'd0, m_bekle});
    end

    if (!r) begin
      exp_q.delete(); m_ps = 32'd0; m_bekle = 0; m_atla = 0; model_known = 1;
    end else if (model_known) begin
      if (atl) begin
        exp_q.delete();
        m_ps    = hd;
        m_atla  = (int'(hd[7:0]) % (2 * H)) / 2;
        m_bekle = (m_atla != 0);
      end else begin
        was_empty = (exp_q.size() == 0);
        if (e_val && hz) begin
          repeat (e_sik ? 1 : 2) void'(exp_q.pop_front());
          m_ps = m_ps + (e_sik ? 32'd2 : 32'd4);
        end
        if (g && e_hazir) begin
          from = m_bekle ? m_atla : 0;
          if (!m_bekle && was_empty) m_ps = p;
          m_bekle = 0;
          for (int i = from; i < H; i++) exp_q.push_back(d[i*16 +: 16]);
        end
      end
    end
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input bit hz);
    step(1, 0, '0, 32'd0, 0, 32'd0, hz);
  endtask

  task automatic push(input logic [GG-1:0] d, input logic [31:0] p, input bit hz);
    step(1, 1, d, p, 0, 32'd0, hz);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [GG-1:0] rd;
    logic [15:0]   hw;
    @(negedge clk);
    step(0, 0, '0, 32'd0, 0, 32'd0, 0);
    step(0, 0, '0, 32'd0, 0, 32'd0, 0);

    // reset values
    idle(1);
    chk("rst_gecerli", {31'd0, c_gec}, 32'd0);
    chk("rst_buyruk", c_buyruk, 32'd0);
    chk("rst_ps", c_ps, 32'd0);
    chk("rst_hazir", {31'd0, c_hazir}, 32'd1);

    // single full instruction
    push(32'h00A00093, 32'h100, 1);
    idle(1);
    chk("t1_buyruk", c_buyruk, 32'h00A00093);
    chk("t1_ps", c_ps, 32'h100);
    chk("t1_sik", {31'd0, c_sik}, 32'd0);
    idle(1);
    chk("t1_sayac", c_sayac, 0);

    // two compressed
    push(32'h45854505, 32'h104, 1);
    idle(1);
    chk("t2a_buyruk", c_buyruk, 32'h00004505);
    chk("t2a_ps", c_ps, 32'h104);
    idle(1);
    chk("t2b_buyruk", c_buyruk, 32'h00004585);
    chk("t2b_ps", c_ps, 32'h106);
    chk("t2b_sik", {31'd0, c_sik}, 32'd1);

    // straddle
    push(32'h00134501, 32'h200, 1);
    idle(1);
    chk("t3a_buyruk", c_buyruk, 32'h00004501);
    chk("t3a_ps", c_ps, 32'h200);
    idle(1);
    chk("t3_bekle", {31'd0, c_gec}, 32'd0);
    push(32'h00000000, 32'h204, 1);
    idle(1);
    chk("t3b_buyruk", c_buyruk, 32'h00000013);
    chk("t3b_ps", c_ps, 32'h202);
    chk("t3b_sik", {31'd0, c_sik}, 32'd0);
    idle(1);

    // misaligned redirect
    step(1, 0, '0, 32'd0, 1, 32'h302, 1);
    push(32'h00930000, 32'h300, 1);
    chk("t4_durum", {31'd0, c_durum}, 32'd1);
    idle(1);
    chk("t4_bekle", {31'd0, c_gec}, 32'd0);
    push(32'h123400A0, 32'h304, 1);
    idle(1);
    chk("t4_buyruk", c_buyruk, 32'h00A00093);
    chk("t4_ps", c_ps, 32'h302);
    idle(1);
    chk("t4_sonraki", c_buyruk, 32'h00001234);

    // backpressure and wrap
    for (int k = 0; k < 4; k++)
      push({16'h1000 + 16'((2*k+1)*4), 16'h1000 + 16'((2*k)*4)}, 32'h400 + 32'(4*k), 0);
    push(32'hFFFFFFFF, 32'h410, 0);
    chk("t5_hazir", {31'd0, c_hazir}, 32'd0);
    chk("t5_sayac", c_sayac, 8);
    for (int k = 0; k < 8; k++) begin
      idle(1);
      chk("t5_buyruk", c_buyruk, {16'd0, 16'h1000 + 16'(4*k)});
      chk("t5_ps", c_ps, 32'h400 + 32'(2*k));
    end

    // redirect colliding with push and pending pop
    push(32'h45854505, 32'h500, 0);
    idle(0);
    chk("t6_gecerli", {31'd0, c_gec}, 32'd1);
    step(1, 1, 32'h11111111, 32'h504, 1, 32'h600, 1);
    chk("t6_bastir", {31'd0, c_gec}, 32'd0);
    idle(0);
    chk("t6_sayac", c_sayac, 0);
    chk("t6_ps", c_ps, 32'h600);

    // reset while waiting for a redirect target
    step(1, 0, '0, 32'd0, 1, 32'h702, 0);
    idle(0);
    chk("t6_durum", {31'd0, c_durum}, 32'd1);
    step(0, 0, '0, 32'd0, 0, 32'd0, 1);
    idle(1);
    chk("t6r_durum", {31'd0, c_durum}, 32'd0);
    chk("t6r_ps", c_ps, 32'd0);
    chk("t6r_hazir", {31'd0, c_hazir}, 32'd1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < H; i++) begin
        hw = 16'($urandom());
        if ($urandom_range(0, 1) == 0) hw[1:0] = 2'b11;
        rd[i*16 +: 16] = hw;
      end
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 1) == 1),
           rd,
           $urandom() & 32'hFFFF_FFFC,
           ($urandom_range(0, 29) == 0),
           $urandom() & 32'hFFFF_FFFE,
           ($urandom_range(0, 9) < 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
